latq_bank_wctl: RTL

LATQ_BANK_WCTL -- requirements
Module: latq_bank_wctl

---
 rtl/latq_bank_wctl_if.sv | 26 ++
 rtl/latq_bank_wctl.sv | 103 ++++++++++
 2 files changed

// File: rtl/latq_bank_wctl_if.sv
// Write-request / latch-bank bus between a requester and the latch write controller.
interface latq_bank_wctl_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
);
    logic              WR_VALID;
    logic [AW-1:0]     WR_ADDR;
    logic [DW-1:0]     WR_DATA;
    logic              WR_READY;
    logic [DW-1:0]     LAT_D;
    logic [DEPTH-1:0]  LAT_E;
    logic              ADDR_ERR;

    // Requester side: issues writes, observes the latch-bank drive.
    modport master (
        output WR_VALID, WR_ADDR, WR_DATA,
        input  WR_READY, LAT_D, LAT_E, ADDR_ERR
    );

    // Controller side.
    modport slave (
        input  WR_VALID, WR_ADDR, WR_DATA,
        output WR_READY, LAT_D, LAT_E, ADDR_ERR
    );
endinterface

// File: rtl/latq_bank_wctl.sv
// Write controller for a bank of level-sensitive latches. Each accepted write
// presents data for a setup cycle, opens exactly one enable for OPEN_CYC cycles,
// then holds data one more cycle before accepting the next request.
module latq_bank_wctl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned OPEN_CYC = 1
) (
    input  logic              CLK,
    input  logic              RN,
    latq_bank_wctl_if.slave   bus
);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     lat_d_q;
    logic [DEPTH-1:0]  lat_e_q;
    logic              err_q;
    logic              rdy_q;

    logic [DEPTH-1:0]  dec_d;
    logic              addr_bad_c;

    // One-hot decode of the captured address; out-of-range addresses decode to zero.
    always_comb begin
        dec_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (addr_q == AW'(i)) begin
                dec_d[i] = 1'b1;
            end
        end
    end

    // Range check on the incoming address, registered into ADDR_ERR at acceptance.
    assign addr_bad_c = (32'(bus.WR_ADDR) >= 32'(DEPTH));

    // Sequencer: state, open-window counter and all latch-facing outputs.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lat_d_q <= '0;
            lat_e_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    // rdy_q is still 0 on the reset-release edge, so nothing is taken there
                    if (bus.WR_VALID && rdy_q) begin
                        state_q <= SETUP;
                        lat_d_q <= bus.WR_DATA;
                        addr_q  <= bus.WR_ADDR;
                        err_q   <= addr_bad_c;
                        rdy_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    err_q   <= 1'b0;
                    lat_e_q <= dec_d;
                    cnt_q   <= CW'(OPEN_CYC);
                    state_q <= OPEN;
                end
                OPEN: begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_q   <= '0;
                        lat_e_q <= '0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    lat_e_q <= '0;
                    rdy_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.WR_READY = rdy_q;
    assign bus.LAT_D    = lat_d_q;
    assign bus.LAT_E    = lat_e_q;
    assign bus.ADDR_ERR = err_q;

endmodule
